shiftreg_serializer: RTL and testbench
======================================

// Module: shiftreg_serializer
// PURPOSE
//  Parallel-in, serial-out shift register: the transmit-side counterpart of the serial-in bit shift register.
//  Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per consumer strobe.
//  Flags the final bit of each word.
//  Holds one word shifting and one word pending, so back-to-back words stream with no bubble bit.
// PARAMETERS
//  WIDTH      32  bits per word; legal range >= 2
//  MSB_FIRST  1   1: bit WIDTH-1 emitted first; 0: bit 0 emitted first
// PORTS
//  CLK          in   1      clock; all state updates on posedge
//  RST          in   1      asynchronous, active-high reset
//  enqData      in   WIDTH  parallel word to serialize
//  enqValid     in   1      enqData valid
//  enqReady     out  1      block can accept a word this cycle
//  shiftEnable  in   1      consumer takes serialData this cycle (ignored when serialValid=0)
//  serialData   out  1      current output bit
//  serialValid  out  1      serialData holds a live bit
//  serialLast   out  1      current bit is the last bit of its word
// BEHAVIOUR
//  Reset (async assert; deassert sampled on CLK):
//  - serialValid=0, serialData=0, serialLast=0, enqReady=1.
//  - Bit counter=0, pending buffer empty, state EMPTY.
//  Storage:
//  - Active shift register plus bit counter cnt (0..WIDTH-1).
//  - Pending word register plus pendFull flag.
//  Handshakes:
//  - enq fires when enqValid & enqReady.
//  - A bit is consumed when shiftEnable & serialValid.
//  - enqReady = !pendFull, registered; no combinational path from shiftEnable or enqValid.
//  States:
//  - EMPTY: serialValid=0. On enq: load active, cnt=0, go to ACTIVE. First bit is visible the cycle after enq (latency 1).
//  - ACTIVE: serialValid=1. serialData = active[WIDTH-1] if MSB_FIRST, else active[0]. serialLast = (cnt==WIDTH-1).
//  Consume in ACTIVE with cnt<WIDTH-1: shift toward the output end, cnt+1, zero-fill.
//  Consume of last bit (cnt==WIDTH-1):
//  - pendFull: load pending into active, cnt=0, pendFull=0, stay ACTIVE.
//  - else enq in the same cycle: load enqData directly into active, stay ACTIVE (flow-through, no bubble).
//  - else: go to EMPTY.
//  Enq in ACTIVE without last-bit consume: word goes to pending, pendFull=1.
//  No consume: outputs and state hold indefinitely; stalls are unbounded.
//  shiftEnable while serialValid=0: no effect.
//  enqValid while enqReady=0: no effect. The producer must hold the word until it is accepted.
//  Word order: strictly FIFO. Bit order within a word is set by MSB_FIRST.
//  Reset mid-word: the partial word and the pending word are discarded. Outputs go to reset values immediately, without waiting for CLK.
// TESTING
//  1. WIDTH=8, MSB_FIRST=1; enq 0xA5; shiftEnable=1 constantly
//     -> serialData 1,0,1,0,0,1,0,1 on the 8 cycles after enq; serialLast only on the 8th; then serialValid=0.
//  2. Same configuration; enq 0xA5, 0x3C, 0xFF back-to-back with shiftEnable=1
//     -> 24 contiguous valid bits; serialLast at bits 8, 16 and 24; no gap cycle.
//  3. shiftEnable=0 after enq of 0xA5 and 0x0F, third enq attempted
//     -> enqReady=0 from the cycle after the 2nd enq; 3rd word not taken; serialData holds 1.
//     -> Release shiftEnable: enqReady returns 1 the cycle after the last bit of 0xA5 is consumed.
//  4. MSB_FIRST=0, WIDTH=8, enq 0x01
//     -> bits 1,0,0,0,0,0,0,0; serialLast on the 8th bit.
//  5. Assert RST asynchronously after 3 bits of 0xA5, with a pending word held
//     -> serialValid=0, serialLast=0, enqReady=1 before the next CLK edge.
//     -> After release, enq 0x81 yields 1,0,0,0,0,0,0,1 with no residue from the old words.
//  6. Toggle shiftEnable randomly while in EMPTY and in ACTIVE
//     -> bits consumed only when shiftEnable & serialValid; sequence matches a reference model.

Source files
------------

// File: rtl/shiftreg_serializer.sv
// Parallel-in, serial-out shift register with a one-word pending buffer.
// Words arrive on a valid/ready handshake and leave one bit per consumer strobe.
module shiftreg_serializer #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] enqData,
  input  logic             enqValid,
  output logic             enqReady,
  input  logic             shiftEnable,
  output logic             serialData,
  output logic             serialValid,
  output logic             serialLast
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {EMPTY, ACTIVE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] active, active_nxt;
  logic [WIDTH-1:0] pend, pend_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             pend_full, pend_full_nxt;

  logic             enq_fire;
  logic             consume;
  logic             last_bit;
  logic [WIDTH-1:0] shifted;

  // enqReady comes straight from a flop, so it never depends on this cycle's inputs.
  assign enqReady    = !pend_full;
  assign serialValid = (state == ACTIVE);
  assign last_bit    = (cnt == CNT_LAST);
  assign serialLast  = serialValid & last_bit;
  assign serialData  = serialValid & (MSB_FIRST ? active[WIDTH-1] : active[0]);

  assign enq_fire = enqValid & !pend_full;
  assign consume  = shiftEnable & serialValid;
  assign shifted  = MSB_FIRST ? {active[WIDTH-2:0], 1'b0} : {1'b0, active[WIDTH-1:1]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= EMPTY;
      active    <= '0;
      pend      <= '0;
      cnt       <= '0;
      pend_full <= 1'b0;
    end else begin
      state     <= state_nxt;
      active    <= active_nxt;
      pend      <= pend_nxt;
      cnt       <= cnt_nxt;
      pend_full <= pend_full_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    active_nxt    = active;
    pend_nxt      = pend;
    cnt_nxt       = cnt;
    pend_full_nxt = pend_full;
    case (state)
      EMPTY: begin
        if (enq_fire) begin
          active_nxt = enqData;
          cnt_nxt    = '0;
          state_nxt  = ACTIVE;
        end
      end
      ACTIVE: begin
        if (consume && last_bit) begin
          // pend_full blocks enq_fire, so the pending word always wins over flow-through
          if (pend_full) begin
            active_nxt    = pend;
            cnt_nxt       = '0;
            pend_full_nxt = 1'b0;
          end else if (enq_fire) begin
            active_nxt = enqData;
            cnt_nxt    = '0;
          end else begin
            state_nxt = EMPTY;
          end
        end else begin
          if (consume) begin
            active_nxt = shifted;
            cnt_nxt    = cnt + 1'b1;
          end
          if (enq_fire) begin
            pend_nxt      = enqData;
            pend_full_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

endmodule

// File: tb/tb_shiftreg_serializer.sv
// Bench for shiftreg_serializer: MSB-first and LSB-first instances share stimulus,
// checked against hand-computed vectors and a bit-queue reference model.
module tb_shiftreg_serializer;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] enq_data;
  logic         enq_valid;
  logic         shift_en;
  logic         m_ready, m_data, m_valid, m_last;
  logic         l_ready, l_data, l_valid, l_last;

  shiftreg_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .CLK(CLK), .RST(RST), .enqData(enq_data), .enqValid(enq_valid), .enqReady(m_ready),
    .shiftEnable(shift_en), .serialData(m_data), .serialValid(m_valid), .serialLast(m_last));

  shiftreg_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .CLK(CLK), .RST(RST), .enqData(enq_data), .enqValid(enq_valid), .enqReady(l_ready),
    .shiftEnable(shift_en), .serialData(l_data), .serialValid(l_valid), .serialLast(l_last));

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: every stored bit in emission order, tagged with its last-of-word flag.
  typedef struct { bit d; bit l; } mbit_t;
  mbit_t qm[$];
  mbit_t ql[$];
  bit    mdl_fire, mdl_cons;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      qm.delete();
      ql.delete();
    end else begin
      mdl_fire = enq_valid && (qm.size() <= W);
      mdl_cons = shift_en && (qm.size() > 0);
      if (mdl_cons) begin
        qm.delete(0);
        ql.delete(0);
      end
      if (mdl_fire)
        for (int i = 0; i < W; i++) begin
          qm.push_back('{enq_data[W-1-i], i == W-1});
          ql.push_back('{enq_data[i], i == W-1});
        end
    end
  end

  task automatic check_model(input string tag);
    check({tag, "_m_valid"}, m_valid, qm.size() > 0);
    check({tag, "_l_valid"}, l_valid, ql.size() > 0);
    check({tag, "_m_ready"}, m_ready, qm.size() <= W);
    check({tag, "_l_ready"}, l_ready, ql.size() <= W);
    if (qm.size() > 0) begin
      check({tag, "_m_data"}, m_data, qm[0].d);
      check({tag, "_m_last"}, m_last, qm[0].l);
      check({tag, "_l_data"}, l_data, ql[0].d);
      check({tag, "_l_last"}, l_last, ql[0].l);
    end
  endtask

  typedef struct {
    logic [W-1:0] word;
    logic [W-1:0] exp_msb;  // emission order, first bit in [W-1]
    logic [W-1:0] exp_lsb;
  } vec_t;

  vec_t vecs[4];

  logic [23:0]  stream;
  logic [W-1:0] words[3];
  logic [W-1:0] exp_bits;
  int           wi;
  bit           accepted;

  initial begin
    vecs[0] = '{8'hA5, 8'hA5, 8'hA5};
    vecs[1] = '{8'h01, 8'h01, 8'h80};
    vecs[2] = '{8'hC2, 8'hC2, 8'h43};
    vecs[3] = '{8'h1E, 8'h1E, 8'h78};

    RST = 1'b1; enq_data = '0; enq_valid = 1'b0; shift_en = 1'b0;
    #12;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data",  m_data,  0);
    check("rst_m_last",  m_last,  0);
    check("rst_m_ready", m_ready, 1);
    check("rst_l_valid", l_valid, 0);
    check("rst_l_ready", l_ready, 1);
    @(negedge CLK); RST = 1'b0;
    tick();

    // single words, continuous consume, both bit orders
    foreach (vecs[v]) begin
      enq_data = vecs[v].word; enq_valid = 1'b1; shift_en = 1'b1;
      tick();
      enq_valid = 1'b0;
      for (int i = 0; i < W; i++) begin
        check("vec_m_valid", m_valid, 1);
        check("vec_m_data",  m_data,  vecs[v].exp_msb[W-1-i]);
        check("vec_m_last",  m_last,  i == W-1);
        check("vec_l_data",  l_data,  vecs[v].exp_lsb[W-1-i]);
        check("vec_l_last",  l_last,  i == W-1);
        tick();
      end
      check("vec_m_idle", m_valid, 0);
      check("vec_l_idle", l_valid, 0);
    end

    // three words back-to-back: 24 contiguous bits
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
    stream = {words[0], words[1], words[2]};
    enq_data = words[0]; enq_valid = 1'b1; shift_en = 1'b1;
    tick();
    wi = 1; enq_data = words[1];
    for (int k = 0; k < 24; k++) begin
      check("b2b_valid", m_valid, 1);
      check("b2b_data",  m_data,  stream[23-k]);
      check("b2b_last",  m_last,  (k % 8) == 7);
      accepted = enq_valid && m_ready;
      tick();
      if (accepted) begin
        wi++;
        if (wi < 3) enq_data = words[wi];
        else enq_valid = 1'b0;
      end
    end
    check("b2b_words_taken", wi, 3);
    check("b2b_idle", m_valid, 0);

    // stall with pending word; third word refused
    shift_en = 1'b0; enq_data = 8'hA5; enq_valid = 1'b1;
    tick();
    check("stall_ready_1st", m_ready, 1);
    enq_data = 8'h0F;
    tick();
    check("stall_ready_2nd", m_ready, 0);
    enq_data = 8'h77;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_ready", m_ready, 0);
      check("stall_data",  m_data,  1);
      check("stall_valid", m_valid, 1);
      check("stall_last",  m_last,  0);
    end
    enq_valid = 1'b0; shift_en = 1'b1;
    for (int i = 0; i < W; i++) begin
      check("drain_a5_ready", m_ready, 0);
      tick();
    end
    check("drain_ready_back", m_ready, 1);
    exp_bits = 8'h0F;
    for (int i = 0; i < W; i++) begin
      check("drain_0f_data",  m_data,  exp_bits[W-1-i]);
      check("drain_0f_valid", m_valid, 1);
      check("drain_0f_last",  m_last,  i == W-1);
      tick();
    end
    check("drain_no_third", m_valid, 0);

    // async reset mid-word with a pending word held
    enq_data = 8'hA5; enq_valid = 1'b1; shift_en = 1'b1;
    tick();
    enq_data = 8'h0F;
    tick();
    enq_valid = 1'b0;
    tick();
    tick();
    check("pre_rst_ready", m_ready, 0);
    #2 RST = 1'b1;
    #1;
    check("arst_m_valid", m_valid, 0);
    check("arst_m_last",  m_last,  0);
    check("arst_m_data",  m_data,  0);
    check("arst_m_ready", m_ready, 1);
    check("arst_l_ready", l_ready, 1);
    @(negedge CLK); RST = 1'b0;
    enq_data = 8'h81; enq_valid = 1'b1; shift_en = 1'b1;
    tick();
    enq_valid = 1'b0;
    exp_bits = 8'h81;
    for (int i = 0; i < W; i++) begin
      check("post_rst_m_data", m_data, exp_bits[W-1-i]);
      check("post_rst_l_data", l_data, exp_bits[W-1-i]);
      check("post_rst_last",   m_last, i == W-1);
      tick();
    end
    check("post_rst_idle", m_valid, 0);

    // randomized traffic against the reference model
    shift_en = 1'b0; enq_valid = 1'b0;
    tick();
    for (int n = 0; n < 600; n++) begin
      if (n < 300) shift_en = ($urandom_range(0, 3) != 0);
      else         shift_en = ($urandom_range(0, 3) == 0);
      if (!enq_valid && ($urandom_range(0, 2) != 0)) begin
        enq_valid = 1'b1;
        enq_data  = W'($urandom);
      end
      check_model("rnd");
      accepted = enq_valid && m_ready;
      tick();
      if (accepted) enq_valid = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
